inst_fetch_unit: RTL

Read-side initiator for the instruction memory. It drives the memory's chip-select, write-enable and read-address pins, and collects IBYTES consecutive DWIDTH-bit words into one instruction. It presents each instruction on a valid/ready interface to the decode stage. It sits between the instruction memory and the core's decode logic and never writes to memory.

---
 rtl/inst_fetch_unit.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//   Read-side initiator for the instruction memory. It issues IBYTES
//   consecutive word reads and assembles them little-endian into one
//   instruction. The instruction is then offered to decode on a valid/ready
//   handshake. The unit never writes memory.
//
// Ports
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_start, i_start_pc      one-cycle pulse to begin fetching (IDLE only)
//   i_redirect, i_redirect_pc  flush and restart, highest priority
//   o_mem_csb/o_mem_web/o_mem_addr  memory pins (csb=0 access, web fixed 1)
//   i_mem_data               read data, valid the cycle after an access
//   o_inst_valid/i_inst_ready  handshake towards decode
//   o_inst, o_inst_pc        assembled instruction and its address
//   o_busy                   unit has left IDLE
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
  parameter int DWIDTH = 8,
  parameter int ADDR   = 10,
  parameter int IBYTES = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [ADDR-1:0]          i_start_pc,
  input  logic                     i_redirect,
  input  logic [ADDR-1:0]          i_redirect_pc,
  output logic                     o_mem_csb,
  output logic                     o_mem_web,
  output logic [ADDR-1:0]          o_mem_addr,
  input  logic [DWIDTH-1:0]        i_mem_data,
  output logic                     o_inst_valid,
  input  logic                     i_inst_ready,
  output logic [IBYTES*DWIDTH-1:0] o_inst,
  output logic [ADDR-1:0]          o_inst_pc,
  output logic                     o_busy
);

  localparam int IDXW = $clog2(IBYTES);
  localparam int CNTW = IDXW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [ADDR-1:0]            pc_q, pc_d;
  logic [CNTW-1:0]            cnt_q, cnt_d;         // index of the next word to issue
  logic [IDXW-1:0]            req_idx_q, req_idx_d; // word index currently on the bus
  logic                       rd_pend_q, rd_pend_d; // i_mem_data holds a word to capture
  logic [IDXW-1:0]            rd_idx_q, rd_idx_d;   // slot that word belongs to
  logic                       csb_q, csb_d;
  logic                       web_q, web_d;
  logic [ADDR-1:0]            addr_q, addr_d;
  logic                       valid_q, valid_d;
  logic [IBYTES*DWIDTH-1:0]   inst_q, inst_d;
  logic [ADDR-1:0]            inst_pc_q, inst_pc_d;
  logic                       busy_q, busy_d;
  logic [ADDR-1:0]            next_pc_s;

  assign next_pc_s = pc_q + ADDR'(IBYTES);

  // Next-state, memory command and instruction assembly.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    req_idx_d = req_idx_q;
    // A read on the bus this cycle returns data next cycle.
    rd_pend_d = ~csb_q;
    rd_idx_d  = req_idx_q;
    csb_d     = 1'b1;
    web_d     = 1'b1;
    addr_d    = addr_q;
    valid_d   = valid_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;

    // Capture returning data, unless a redirect is discarding it.
    if (rd_pend_q && !i_redirect) begin
      inst_d[rd_idx_q*DWIDTH +: DWIDTH] = i_mem_data;
    end else begin
      inst_d = inst_q;
    end

    if (i_redirect) begin
      state_d   = ISSUE;
      pc_d      = i_redirect_pc;
      csb_d     = 1'b0;
      addr_d    = i_redirect_pc;
      cnt_d     = CNTW'(1);
      req_idx_d = IDXW'(0);
      rd_pend_d = 1'b0;
      valid_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            state_d   = ISSUE;
            pc_d      = i_start_pc;
            csb_d     = 1'b0;
            addr_d    = i_start_pc;
            cnt_d     = CNTW'(1);
            req_idx_d = IDXW'(0);
          end else begin
            state_d = IDLE;
          end
        end
        ISSUE: begin
          // Word 0 was issued on entry, so ISSUE spans exactly IBYTES cycles.
          if (cnt_q == CNTW'(IBYTES)) begin
            state_d = DRAIN;
          end else begin
            csb_d     = 1'b0;
            addr_d    = pc_q + ADDR'(cnt_q);
            req_idx_d = cnt_q[IDXW-1:0];
            cnt_d     = cnt_q + CNTW'(1);
          end
        end
        DRAIN: begin
          if (rd_pend_q && (rd_idx_q == IDXW'(IBYTES - 1))) begin
            state_d   = HOLD;
            valid_d   = 1'b1;
            inst_pc_d = pc_q;
          end else begin
            state_d = DRAIN;
          end
        end
        HOLD: begin
          if (valid_q && i_inst_ready) begin
            state_d   = ISSUE;
            pc_d      = next_pc_s;
            csb_d     = 1'b0;
            addr_d    = next_pc_s;
            cnt_d     = CNTW'(1);
            req_idx_d = IDXW'(0);
            valid_d   = 1'b0;
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      cnt_q     <= '0;
      req_idx_q <= '0;
      rd_pend_q <= 1'b0;
      rd_idx_q  <= '0;
      csb_q     <= 1'b1;
      web_q     <= 1'b1;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      req_idx_q <= req_idx_d;
      rd_pend_q <= rd_pend_d;
      rd_idx_q  <= rd_idx_d;
      csb_q     <= csb_d;
      web_q     <= web_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      busy_q    <= busy_d;
    end
  end

  assign o_mem_csb    = csb_q;
  assign o_mem_web    = web_q;
  assign o_mem_addr   = addr_q;
  assign o_inst_valid = valid_q;
  assign o_inst       = inst_q;
  assign o_inst_pc    = inst_pc_q;
  assign o_busy       = busy_q;

endmodule
